// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the PIO-style instruction encoder.
// Holds the controller state encoding, the sticky error codes and the
// default instruction-memory depth used by the encoder and its packer.
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } enc_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_DELAY    = 3'd1;  // delay does not fit its field
    localparam logic [2:0] ERR_SIDESET  = 3'd2;  // side-set value/enable not encodable
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;  // program filled memory without in_last
    localparam logic [2:0] ERR_COUNT    = 3'd4;  // configured side-set count above 5

    localparam int         MEM_DEPTH_DEFAULT = 32;
    localparam logic [2:0] MAX_SIDESET_COUNT = 3'd5;

endpackage

// File: rtl/instruction_encoder_opcode_packer.sv
// opcode_packer: combinational packing of one instruction into its 16-bit
// opcode, the inverse of the decoder's field extraction, plus range checks.
// Ports:
//   side_count_i  - latched side-set count (0..5)
//   side_mode_i   - side-set enable mode (top bit of the field is the enable)
//   instruction_i - 3-bit opcode class          -> data_o[15:13]
//   delay_i       - requested delay cycles      -> low bits of data_o[12:8]
//   side_enable_i - per-instruction side-set enable (only used in enable mode)
//   side_set_i    - side-set value              -> high bits of data_o[12:8]
//   params_i      - instruction parameters      -> data_o[7:0]
//   data_o        - packed opcode
//   error_o       - ERR_NONE, ERR_DELAY or ERR_SIDESET
module opcode_packer
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  side_count_i,
    input  logic        side_mode_i,
    input  logic [2:0]  instruction_i,
    input  logic [4:0]  delay_i,
    input  logic        side_enable_i,
    input  logic [4:0]  side_set_i,
    input  logic [7:0]  params_i,
    output logic [15:0] data_o,
    output logic [2:0]  error_o
);

    logic [2:0] delay_count;
    logic [2:0] side_width;
    logic [4:0] side_shifted;
    logic [4:0] field;

    always_comb begin
        // The 5-bit field is shared: side-set on top, delay underneath.
        delay_count = MAX_SIDESET_COUNT - side_count_i;

        // In enable mode one of the side-set bits is spent on the enable flag.
        if (side_mode_i) begin
            side_width = (side_count_i == 3'd0) ? 3'd0 : side_count_i - 3'd1;
        end else begin
            side_width = side_count_i;
        end

        side_shifted = side_set_i << delay_count;
        field        = side_shifted | delay_i;
        // With a zero count there is no side-set field at all, so bit 4
        // still belongs to the delay and must not be overwritten.
        if (side_mode_i && (side_count_i != 3'd0)) begin
            field[4] = side_enable_i;
        end

        data_o = {instruction_i, field, params_i};

        error_o = ERR_NONE;
        if ((delay_i >> delay_count) != 5'd0) begin
            error_o = ERR_DELAY;
        end else if (((side_set_i >> side_width) != 5'd0) ||
                     (side_mode_i && (side_count_i == 3'd0) && side_enable_i)) begin
            error_o = ERR_SIDESET;
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts a stream of instruction fields over a
// valid/ready handshake, packs each into a 16-bit opcode and writes it to
// consecutive instruction-memory addresses, one instruction per 2 cycles.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_smPinCtrl[31:29]   - side-set count, latched at in_start
//   in_smExecCtrl[30]     - side-set enable mode, latched at in_start
//   in_start/in_startAddr - begin a program load at the given address
//   in_valid/out_ready    - instruction handshake; in_last marks the final one
//   in_instruction, in_delay, in_sideEnable, in_sideSet, in_instructionParams
//                         - fields of the instruction being transferred
//   out_memWrite/out_memAddr/out_memData - one-cycle memory write strobe
//   out_busy              - load in progress (ACCEPT or WRITE)
//   out_done              - one-cycle pulse after the final write
//   out_error             - sticky error code, held until the next in_start
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_smPinCtrl,
    input  logic [31:0] in_smExecCtrl,
    input  logic        in_start,
    input  logic [4:0]  in_startAddr,
    input  logic        in_valid,
    output logic        out_ready,
    input  logic        in_last,
    input  logic [2:0]  in_instruction,
    input  logic [4:0]  in_delay,
    input  logic        in_sideEnable,
    input  logic [4:0]  in_sideSet,
    input  logic [7:0]  in_instructionParams,
    output logic        out_memWrite,
    output logic [4:0]  out_memAddr,
    output logic [15:0] out_memData,
    output logic        out_busy,
    output logic        out_done,
    output logic [2:0]  out_error
);

    localparam int                WCNT_W      = $clog2(MEM_DEPTH + 1);
    localparam logic [WCNT_W-1:0] LAST_WCOUNT = WCNT_W'(MEM_DEPTH - 1);

    enc_state_e        state_q, state_d;
    logic [2:0]        side_count_q, side_count_d;
    logic              side_mode_q, side_mode_d;
    logic [4:0]        addr_q, addr_d;
    logic [WCNT_W-1:0] wcount_q, wcount_d;
    logic [4:0]        mem_addr_q, mem_addr_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic              last_q, last_d;
    logic [2:0]        error_q, error_d;

    logic [2:0]        cfg_count;
    logic [15:0]       pack_data;
    logic [2:0]        pack_error;
    logic              unused_ctrl_bits;

    assign cfg_count        = in_smPinCtrl[31:29];
    assign unused_ctrl_bits = ^{in_smPinCtrl[28:0], in_smExecCtrl[31], in_smExecCtrl[29:0]};

    opcode_packer u_packer (
        .side_count_i  (side_count_q),
        .side_mode_i   (side_mode_q),
        .instruction_i (in_instruction),
        .delay_i       (in_delay),
        .side_enable_i (in_sideEnable),
        .side_set_i    (in_sideSet),
        .params_i      (in_instructionParams),
        .data_o        (pack_data),
        .error_o       (pack_error)
    );

    always_comb begin
        state_d      = state_q;
        side_count_d = side_count_q;
        side_mode_d  = side_mode_q;
        addr_d       = addr_q;
        wcount_d     = wcount_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        last_d       = last_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (in_start) begin
                    if (cfg_count > MAX_SIDESET_COUNT) begin
                        error_d = ERR_COUNT;
                        state_d = ST_ERROR;
                    end else begin
                        side_count_d = cfg_count;
                        side_mode_d  = in_smExecCtrl[30];
                        addr_d       = in_startAddr;
                        wcount_d     = '0;
                        error_d      = ERR_NONE;
                        state_d      = ST_ACCEPT;
                    end
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (pack_error != ERR_NONE) begin
                        error_d = pack_error;
                        state_d = ST_ERROR;
                    end else begin
                        mem_data_d = pack_data;
                        mem_addr_d = addr_q;
                        last_d     = in_last;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d   = addr_q + 5'd1;  // wraps 31 -> 0
                wcount_d = wcount_q + 1'b1;
                if (last_q) begin
                    state_d = ST_DONE;
                end else if (wcount_q == LAST_WCOUNT) begin
                    error_d = ERR_OVERFLOW;
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            side_count_q <= '0;
            side_mode_q  <= 1'b0;
            addr_q       <= '0;
            wcount_q     <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            last_q       <= 1'b0;
            error_q      <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            side_count_q <= side_count_d;
            side_mode_q  <= side_mode_d;
            addr_q       <= addr_d;
            wcount_q     <= wcount_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            last_q       <= last_d;
            error_q      <= error_d;
        end
    end

    // Outputs are masked by reset so that a reset landing in WRITE
    // suppresses the write strobe in that very cycle.
    assign out_ready    = !reset && (state_q == ST_ACCEPT);
    assign out_busy     = !reset && ((state_q == ST_ACCEPT) || (state_q == ST_WRITE));
    assign out_memWrite = !reset && (state_q == ST_WRITE);
    assign out_done     = !reset && (state_q == ST_DONE);
    assign out_memAddr  = reset ? 5'd0 : mem_addr_q;
    assign out_memData  = reset ? 16'd0 : mem_data_q;
    assign out_error    = reset ? ERR_NONE : error_q;

endmodule
